// File: rtl/ram_pkg.sv
// Shared types and constants for the simple-dual-port RAM and its clear engine.
package ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } clr_state_e;

    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

endpackage : ram_pkg

// File: rtl/ram_clear_ctrl.sv
// Clear engine: sweeps every address once after reset or on request,
// reporting busy for the whole sweep.
module ram_clear_ctrl
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  busy_q, busy_d;

    // Next state: terminal detect at the last address, so cnt never wraps silently
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        case (state_q)
            ST_CLEAR: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign clr_we   = busy_q;
    assign clr_addr = cnt_q;
    assign busy     = busy_q;

endmodule : ram_clear_ctrl

// File: rtl/ram_sdp_param.sv
// Parametrised simple-dual-port RAM with registered read, selectable
// read-during-write behaviour and a hardware clear sweep.
module ram_sdp_param
    import ram_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH = 8,
    parameter int unsigned            ADDR_WIDTH = 6,
    parameter int unsigned            RDW_MODE   = RDW_OLD,
    parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] q,
    output logic                  rd_valid,
    output logic                  busy
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  busy_int;

    logic                  mem_we_c;
    logic [ADDR_WIDTH-1:0] mem_waddr_c;
    logic [DATA_WIDTH-1:0] mem_wdata_c;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rd_valid_q, rd_valid_d;

    ram_clear_ctrl #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_clear_ctrl (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .clr_we  (clr_we),
        .clr_addr(clr_addr),
        .busy    (busy_int)
    );

    // Write port: the sweep owns the port while busy, user writes are dropped
    always_comb begin
        mem_we_c    = 1'b0;
        mem_waddr_c = '0;
        mem_wdata_c = '0;
        if (!rst) begin
            if (clr_we) begin
                mem_we_c    = 1'b1;
                mem_waddr_c = clr_addr;
                mem_wdata_c = INIT_VALUE;
            end else if (we) begin
                mem_we_c    = 1'b1;
                mem_waddr_c = write_addr;
                mem_wdata_c = data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[mem_waddr_c] <= mem_wdata_c;
        end
    end

    // Read port: write-through bypass only in RDW_NEW mode on an address match
    always_comb begin
        rdata_d    = rdata_q;
        rd_valid_d = 1'b0;
        if (re && !busy_int) begin
            rd_valid_d = 1'b1;
            if ((RDW_MODE == RDW_NEW) && we && (write_addr == read_addr)) begin
                rdata_d = data;
            end else begin
                rdata_d = mem_q[read_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign q        = rdata_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_int;

endmodule : ram_sdp_param

// File: tb/tb_ram_sdp_param.sv
// Bench for ram_sdp_param: three configurations checked against an
// array-level reference model.
module tb_ram_sdp_param;

    logic        clk;
    logic        rst, clr, we, re;
    logic [5:0]  waddr, raddr;
    logic [7:0]  wdata;
    logic [7:0]  q0, q1;
    logic        v0, v1, b0, b1;

    logic        rst2, clr2, we2, re2;
    logic [3:0]  waddr2, raddr2;
    logic [31:0] wdata2, q2;
    logic        v2, b2;

    int checks = 0;
    int errors = 0;

    // Reference model: words, read result, and edges left in the current sweep
    logic [7:0]  m0 [64];
    logic [7:0]  m1 [64];
    logic [31:0] m2 [16];
    logic [7:0]  eq0 = 8'h00, eq1 = 8'h00;
    logic [31:0] eq2 = 32'h0;
    logic        ev01 = 1'b0, ev2 = 1'b0;
    int          left01 = 64, left2 = 16;

    ram_sdp_param #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .RDW_MODE(0), .INIT_VALUE(8'h00)) dut0 (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .write_addr(waddr), .data(wdata),
        .re(re), .read_addr(raddr), .q(q0), .rd_valid(v0), .busy(b0));

    ram_sdp_param #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .RDW_MODE(1), .INIT_VALUE(8'h5A)) dut1 (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .write_addr(waddr), .data(wdata),
        .re(re), .read_addr(raddr), .q(q1), .rd_valid(v1), .busy(b1));

    ram_sdp_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RDW_MODE(0), .INIT_VALUE(32'h0)) dut2 (
        .clk(clk), .rst(rst2), .clr(clr2), .we(we2), .write_addr(waddr2), .data(wdata2),
        .re(re2), .read_addr(raddr2), .q(q2), .rd_valid(v2), .busy(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        clr = 0; we = 0; re = 0; waddr = 0; raddr = 0; wdata = 0;
        clr2 = 0; we2 = 0; re2 = 0; waddr2 = 0; raddr2 = 0; wdata2 = 0;
    endtask

    // One clock edge: advance the model with the inputs seen at that edge
    task automatic step();
        @(posedge clk);
        if (rst) begin
            left01 = 64; ev01 = 0; eq0 = 0; eq1 = 0;
        end else if (left01 > 0) begin
            left01--; ev01 = 0;
            if (left01 == 0)
                for (int i = 0; i < 64; i++) begin m0[i] = 8'h00; m1[i] = 8'h5A; end
        end else begin
            ev01 = re;
            if (re) begin
                eq0 = m0[raddr];
                eq1 = (we && waddr == raddr) ? wdata : m1[raddr];
            end
            if (we) begin m0[waddr] = wdata; m1[waddr] = wdata; end
            if (clr) left01 = 64;
        end
        if (rst2) begin
            left2 = 16; ev2 = 0; eq2 = 0;
        end else if (left2 > 0) begin
            left2--; ev2 = 0;
            if (left2 == 0)
                for (int i = 0; i < 16; i++) m2[i] = 32'h0;
        end else begin
            ev2 = re2;
            if (re2) eq2 = m2[raddr2];
            if (we2) m2[waddr2] = wdata2;
            if (clr2) left2 = 16;
        end
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; rst2 = 1;
        step(); step();
        checks++;
        if (q0 !== 8'h00 || v0 !== 1'b0 || b0 !== 1'b1 || b2 !== 1'b1) begin
            errors++;
            $display("FAIL reset_state q=%h v=%b busy=%b busy2=%b exp q=00 v=0 busy=1 busy2=1", q0, v0, b0, b2);
        end
        rst = 0; rst2 = 0;
        for (int i = 1; i <= 64; i++) begin
            step();
            checks++;
            if (b0 !== (i < 64) || b1 !== (i < 64) || b2 !== (i < 16)) begin
                errors++;
                $display("FAIL reset_sweep_len edge=%0d busy=%b/%b/%b exp %b/%b/%b",
                         i, b0, b1, b2, i < 64, i < 64, i < 16);
            end
        end
        foreach (m0[i]) begin end
        for (int k = 0; k < 3; k++) begin
            logic [5:0] a;
            a = (k == 0) ? 6'd0 : (k == 1) ? 6'd17 : 6'd63;
            re = 1; raddr = a;
            step();
            checks++;
            if (q0 !== 8'h00 || v0 !== 1'b1 || q1 !== 8'h5A || v1 !== 1'b1) begin
                errors++;
                $display("FAIL reset_read addr=%0d q=%h/%h v=%b/%b exp 00/5a 1/1", a, q0, q1, v0, v1);
            end
        end
        idle_inputs();
    endtask

    task automatic test_basic_rw();
        logic [5:0] ra [3];
        logic [7:0] ex [3];
        ra[0] = 6'd10; ra[1] = 6'd5; ra[2] = 6'd16;
        ex[0] = 8'hB3; ex[1] = 8'hAA; ex[2] = 8'h00;
        we = 1; waddr = 5;  wdata = 8'hAA; step();
        we = 1; waddr = 10; wdata = 8'hB3; step();
        we = 0;
        for (int k = 0; k < 3; k++) begin
            re = 1; raddr = ra[k];
            step();
            checks++;
            if (q0 !== ex[k] || v0 !== 1'b1 || q0 !== eq0) begin
                errors++;
                $display("FAIL basic_read addr=%0d q=%h v=%b exp q=%h v=1", ra[k], q0, v0, ex[k]);
            end
        end
        re = 0; raddr = 6'd5;
        step();
        checks++;
        if (v0 !== 1'b0 || q0 !== 8'h00 || v1 !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold q=%h v=%b/%b exp q=00 v=0/0", q0, v0, v1);
        end
        idle_inputs();
    endtask

    task automatic test_rdw();
        we = 1; waddr = 5; wdata = 8'hF0; re = 1; raddr = 5;
        step();
        checks++;
        if (q0 !== 8'hAA || v0 !== 1'b1) begin
            errors++;
            $display("FAIL rdw_old q=%h v=%b exp q=aa v=1", q0, v0);
        end
        checks++;
        if (q1 !== 8'hF0 || v1 !== 1'b1) begin
            errors++;
            $display("FAIL rdw_new q=%h v=%b exp q=f0 v=1", q1, v1);
        end
        we = 0;
        step();
        checks++;
        if (q0 !== 8'hF0 || q1 !== 8'hF0) begin
            errors++;
            $display("FAIL rdw_after q=%h/%h exp f0/f0", q0, q1);
        end
        idle_inputs();
    endtask

    task automatic test_clear();
        for (int a = 0; a < 4; a++) begin
            we = 1; waddr = 6'(a); wdata = 8'(8'h11 * (a + 1));
            step();
        end
        we = 0; clr = 1;
        step();
        clr = 0;
        for (int i = 1; i <= 64; i++) begin
            we = (i > 58); waddr = 6'(i & 3); wdata = 8'hEE;
            re = $urandom_range(0, 1); raddr = 6'($urandom_range(0, 63));
            step();
            checks++;
            if (v0 !== 1'b0 || v1 !== 1'b0 || b0 !== (i < 64) || b1 !== (i < 64)) begin
                errors++;
                $display("FAIL clear_sweep edge=%0d v=%b/%b busy=%b/%b exp v=0 busy=%b",
                         i, v0, v1, b0, b1, i < 64);
            end
        end
        we = 0;
        for (int a = 0; a < 4; a++) begin
            re = 1; raddr = 6'(a);
            step();
            checks++;
            if (q0 !== 8'h00 || q1 !== 8'h5A || v0 !== 1'b1) begin
                errors++;
                $display("FAIL clear_result addr=%0d q=%h/%h v=%b exp 00/5a v=1", a, q0, q1, v0);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_sweep();
        we = 1; waddr = 6'd40; wdata = 8'h77; step();
        we = 0; clr = 1; step();
        clr = 0;
        for (int i = 1; i < 30; i++) step();
        rst = 1; step();
        rst = 0;
        checks++;
        if (v1 !== 1'b0 || b1 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_state v=%b busy=%b exp v=0 busy=1", v1, b1);
        end
        for (int i = 1; i <= 64; i++) begin
            step();
            checks++;
            if (b1 !== (i < 64) || b0 !== (i < 64)) begin
                errors++;
                $display("FAIL midrst_sweep edge=%0d busy=%b/%b exp %b", i, b0, b1, i < 64);
            end
        end
        for (int a = 0; a < 64; a++) begin
            re = 1; raddr = 6'(a);
            step();
            checks++;
            if (q1 !== 8'h5A || q0 !== 8'h00 || v1 !== 1'b1) begin
                errors++;
                $display("FAIL midrst_word addr=%0d q=%h/%h v=%b exp 00/5a v=1", a, q0, q1, v1);
            end
        end
        idle_inputs();
    endtask

    task automatic test_param();
        we2 = 1; waddr2 = 4'd15; wdata2 = 32'hDEADBEEF; step();
        we2 = 0; re2 = 1; raddr2 = 4'd15; step();
        checks++;
        if (q2 !== 32'hDEADBEEF || v2 !== 1'b1) begin
            errors++;
            $display("FAIL param_rw q=%h v=%b exp deadbeef v=1", q2, v2);
        end
        re2 = 0; clr2 = 1; step();
        for (int i = 1; i <= 16; i++) begin
            clr2 = (i == 5);
            step();
            checks++;
            if (b2 !== (i < 16)) begin
                errors++;
                $display("FAIL param_sweep edge=%0d busy=%b exp %b", i, b2, i < 16);
            end
        end
        clr2 = 0; re2 = 1; raddr2 = 4'd15; step();
        checks++;
        if (q2 !== 32'h0 || v2 !== 1'b1) begin
            errors++;
            $display("FAIL param_cleared q=%h v=%b exp 0 v=1", q2, v2);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            we = $urandom_range(0, 1); waddr = 6'($urandom); wdata = 8'($urandom);
            re = $urandom_range(0, 1);
            raddr = ($urandom_range(0, 3) == 0) ? waddr : 6'($urandom);
            clr = ($urandom_range(0, 99) == 0);
            we2 = $urandom_range(0, 1); waddr2 = 4'($urandom); wdata2 = $urandom;
            re2 = $urandom_range(0, 1);
            raddr2 = ($urandom_range(0, 3) == 0) ? waddr2 : 4'($urandom);
            clr2 = ($urandom_range(0, 99) == 0);
            step();
            checks++;
            if (q0 !== eq0 || v0 !== ev01 || b0 !== (left01 != 0) ||
                q1 !== eq1 || v1 !== ev01 || b1 !== (left01 != 0) ||
                q2 !== eq2 || v2 !== ev2  || b2 !== (left2 != 0)) begin
                errors++;
                $display("FAIL random cyc=%0d got q=%h/%h/%h v=%b/%b/%b b=%b/%b/%b exp q=%h/%h/%h v=%b/%b/%b b=%b/%b/%b",
                         n, q0, q1, q2, v0, v1, v2, b0, b1, b2,
                         eq0, eq1, eq2, ev01, ev01, ev2, left01 != 0, left01 != 0, left2 != 0);
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1; rst2 = 1;
        idle_inputs();
        test_reset();
        test_basic_rw();
        test_rdw();
        test_clear();
        test_reset_mid_sweep();
        test_param();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ram_sdp_param
